// File: rtl/deserializer_if.sv
// Serial-in / parallel-out signal bundle for the deserializer.
// master = serial source plus downstream consumer, slave = the deserializer itself.
interface deserializer_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic             sin_valid;
    logic             sin_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             par_err;

    modport master (
        output sin, sin_valid, sin_start, dout_ready,
        input  dout, dout_valid, overrun, par_err
    );

    modport slave (
        input  sin, sin_valid, sin_start, dout_ready,
        output dout, dout_valid, overrun, par_err
    );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit frames onto a valid/ready output register.
// Define PARITY_CHECK_EN to append an even-parity bit to each frame and report mismatches on par_err.
module deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    deserializer_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] sr_first;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             overrun_q;
`ifdef PARITY_CHECK_EN
    logic             word_perr;
    logic             perr_q;
`endif

    // A frame completes on the cycle its final bit (data, or parity when enabled) is sampled.
    always_comb begin
        if (MSB_FIRST != 0) begin
            sr_shift = {sr[WIDTH-2:0], bus.sin};
            sr_first = {{(WIDTH-1){1'b0}}, bus.sin};
        end else begin
            sr_shift = {bus.sin, sr[WIDTH-1:1]};
            sr_first = {bus.sin, {(WIDTH-1){1'b0}}};
        end
        complete = 1'b0;
        word     = sr_shift;
`ifdef PARITY_CHECK_EN
        word_perr = 1'b0;
        if (state == PARITY && bus.sin_valid && !bus.sin_start) begin
            complete  = 1'b1;
            word      = sr;
            word_perr = ^{sr, bus.sin};
        end
`else
        if (state == SHIFT && bus.sin_valid && !bus.sin_start && count == LAST)
            complete = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            sr        <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            // sin_start restarts the frame from any state, discarding partial bits.
            if (bus.sin_valid) begin
                if (bus.sin_start) begin
                    state <= SHIFT;
                    count <= CW'(1);
                    sr    <= sr_first;
                end else begin
                    case (state)
                        SHIFT: begin
                            sr <= sr_shift;
                            if (count == LAST) begin
                                count <= '0;
`ifdef PARITY_CHECK_EN
                                state <= PARITY;
`else
                                state <= IDLE;
`endif
                            end else begin
                                count <= count + CW'(1);
                            end
                        end
`ifdef PARITY_CHECK_EN
                        PARITY: state <= IDLE;
`endif
                        default: ;
                    endcase
                end
            end

            // A new word loads only into an empty or draining register; otherwise it is dropped.
            if (complete && (!valid_q || bus.dout_ready)) begin
                dout_q  <= word;
                valid_q <= 1'b1;
`ifdef PARITY_CHECK_EN
                perr_q  <= word_perr;
`endif
            end else if (complete) begin
                overrun_q <= 1'b1;
            end else if (valid_q && bus.dout_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
    assign bus.par_err    = perr_q;
`else
    assign bus.par_err    = 1'b0;
`endif
endmodule
